// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage
// (port 0, priority) and a secondary bus master (port 1, bounded wait and
// locked bursts). Grant is combinational from requests plus registered state.
module dmem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [2:0]       p0_mode,
    input  logic [WIDTH-1:0] p0_addr,
    input  logic [WIDTH-1:0] p0_wdata,
    output logic             p0_ack,
    output logic [WIDTH-1:0] p0_rdata,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [2:0]       p1_mode,
    input  logic [WIDTH-1:0] p1_addr,
    input  logic [WIDTH-1:0] p1_wdata,
    input  logic             p1_last,
    output logic             p1_ack,
    output logic [WIDTH-1:0] p1_rdata,
    output logic             mem_we,
    output logic [2:0]       mem_mode,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd,
    output logic             stall
);

    typedef enum logic {IDLE, LOCK1} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);
    // A one-beat burst limit means every port-1 beat releases immediately.
    localparam logic       CAN_LOCK   = (BURST_MAX > 1);

    state_t     state;
    logic [3:0] wait_cnt;
    logic [3:0] beat_cnt;
    logic       forced_rel;
    logic       grant0;
    logic       grant1;

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (state == LOCK1) begin
                // Locked: port 1 owns the memory while it keeps requesting;
                // a dropped request frees this very cycle for port 0.
                if (p1_req)      grant1 = 1'b1;
                else if (p0_req) grant0 = 1'b1;
            end else if (forced_rel && p0_req) begin
                // Port 0 gets the cycle right after a burst was cut short.
                grant0 = 1'b1;
            end else if ((wait_cnt == STARVE_LIM) && p1_req) begin
                grant1 = 1'b1;
            end else if (p0_req) begin
                grant0 = 1'b1;
            end else if (p1_req) begin
                grant1 = 1'b1;
            end
        end
    end

    // Memory-side mux of the granted port; idle bus drives zeros.
    always_comb begin
        mem_we   = 1'b0;
        mem_mode = 3'b000;
        mem_addr = '0;
        mem_wd   = '0;
        if (grant0) begin
            mem_we   = p0_we;
            mem_mode = p0_mode;
            mem_addr = p0_addr;
            mem_wd   = p0_wdata;
        end else if (grant1) begin
            mem_we   = p1_we;
            mem_mode = p1_mode;
            mem_addr = p1_addr;
            mem_wd   = p1_wdata;
        end
    end

    assign p0_ack   = grant0;
    assign p1_ack   = grant1;
    assign p0_rdata = mem_rd;
    assign p1_rdata = mem_rd;
    assign stall    = p0_req & ~p0_ack;

    // Lock state, burst beat counter, starvation counter and release flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            beat_cnt   <= 4'd0;
            forced_rel <= 1'b0;
        end else begin
            forced_rel <= 1'b0;

            if (!p1_req || p1_ack)
                wait_cnt <= 4'd0;
            else if (wait_cnt < STARVE_LIM)
                wait_cnt <= wait_cnt + 4'd1;

            case (state)
                IDLE: begin
                    if (p1_ack && !p1_last && CAN_LOCK) begin
                        state    <= LOCK1;
                        beat_cnt <= 4'd1;
                    end
                end
                LOCK1: begin
                    if (!p1_req || p1_last) begin
                        state    <= IDLE;
                        beat_cnt <= 4'd0;
                    end else if (beat_cnt + 4'd1 == BURST_LIM) begin
                        state      <= IDLE;
                        beat_cnt   <= 4'd0;
                        forced_rel <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter in front of the single-port byte-addressed data memory. Shares the memory between the pipeline MEM stage (port 0) and a secondary bus master (port 1: loader/DMA). Port 0 has priority, port 1 gets bounded-latency service and locked bursts. The block also drives the pipeline stall for the MEM stage.

## Interface
- WIDTH, 32, address/data width
- STARVE_MAX, 4, cycles port 1 may wait before a forced grant (1..15)
- BURST_MAX, 8, max beats in one locked port-1 burst (1..15)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- p0_req  in  1  port 0 access request
- p0_we  in  1  port 0 write enable
- p0_mode  in  3  access mode: 001 word, 010 half, 011 byte, 100 half unsigned, 101 byte unsigned
- p0_addr  in  WIDTH  port 0 byte address
- p0_wdata  in  WIDTH  port 0 write data
- p0_ack  out  1  port 0 access performed this cycle
- p0_rdata  out  WIDTH  port 0 read data, valid when p0_ack
- p1_req, p1_we, p1_mode, p1_addr, p1_wdata  in  1/1/3/WIDTH/WIDTH  port 1 equivalents
- p1_last  in  1  current port 1 beat ends its burst
- p1_ack  out  1  port 1 access performed this cycle
- p1_rdata  out  WIDTH  port 1 read data, valid when p1_ack
- mem_we  out  1  memory write enable
- mem_mode  out  3  memory access mode
- mem_addr  out  WIDTH  memory address
- mem_wd  out  WIDTH  memory write data
- mem_rd  in  WIDTH  memory read data (combinational from mem_addr/mem_mode)
- stall  out  1  p0_req & ~p0_ack

## Operation
- Exactly one port granted per cycle, or none. Granted port's we/mode/addr/wdata are muxed to mem_*. No grant: mem_we=0, mem_mode=000, mem_addr=0, mem_wd=0.
- p0_rdata = p1_rdata = mem_rd unconditionally; meaningful only with the matching ack.
- ack = req & grant. A write commits at the rising edge ending the ack cycle.
- States: IDLE, LOCK1.
- IDLE grant rule, in order: wait_cnt == STARVE_MAX and p1_req -> port 1; else p0_req -> port 0; else p1_req -> port 1.
- IDLE -> LOCK1 when port 1 is acked with p1_last=0 and BURST_MAX > 1. beat_cnt loads 1.
- LOCK1: port 1 granted whenever p1_req=1. p0 stalls. Each ack increments beat_cnt.
- LOCK1 -> IDLE when any of the following holds:
  - an ack with p1_last=1;
  - an ack that brings beat_cnt to BURST_MAX (forced release);
  - a cycle with p1_req=0. That cycle is arbitrated as IDLE with port 1 excluded.
- After a forced release, the next cycle grants port 0 if p0_req, regardless of wait_cnt. The remaining port-1 beats re-arbitrate normally.
- wait_cnt (4 bits): increments each cycle p1_req & ~p1_ack, saturating at STARVE_MAX. Cleared on p1_ack or p1_req=0.
- Mode and address are passed through unmodified. No alignment checks or re-encoding.

## Timing
- Zero-latency, combinational grant path from req inputs plus registered state. An uncontended request is acked in the cycle it is asserted.
- Requesters hold req and all qualifiers stable until the ack cycle. Changing them before ack is a protocol error with undefined result.
- Port 1 worst-case wait under continuous port-0 traffic is STARVE_MAX cycles; it is acked in cycle STARVE_MAX+1.
- Port 0 worst-case wait is BURST_MAX cycles.
- Reset (rst_n=0 at a rising edge): state IDLE, wait_cnt=0, beat_cnt=0, forced-release flag 0.
- While rst_n=0: p0_ack=0, p1_ack=0, mem_we=0, mem_mode=000, mem_addr=0, mem_wd=0, stall=p0_req.
- Reset mid-burst drops the lock. First post-reset cycle uses the IDLE rule with wait_cnt=0.
- p0_req and p1_req both asserted in IDLE with wait_cnt<STARVE_MAX: port 0 wins, wait_cnt increments.

## Test plan
- Solo port 0: p0_req, we=1, mode=001, addr=0x10000, wdata=0xDEADBEEF, then a read of the same address -> each acked in the same cycle, stall=0, read returns the stored word per memory byte order.
- Contention, STARVE_MAX=4: p0_req held high, p1_req raised at cycle 0 -> p0_ack in cycles 0-3, p1_ack in cycle 4 with stall=1, then p0 resumes in cycle 5 and wait_cnt=0.
- Burst of 3 beats (p1_last on beat 3) while p0 requests -> p1_ack in 3 consecutive cycles, p0 stalled throughout, p0_ack on the following cycle.
- Overlong burst, BURST_MAX=8, p1_last never set -> 8 p1 acks, p0 acked on the 9th cycle, port 1 re-arbitrates afterwards.
- p1_req drops mid-burst -> lock released the same cycle, p0_ack that cycle if p0_req.
- rst_n low for 1 cycle during beat 2 of a burst -> all acks 0 and mem_we 0 that cycle; next cycle p0 is granted over p1.
